// File: rtl/pipe_execute_md_pkg.sv
// Shared encodings for the RV32IM execute stage: ALU ops, funct3 values and M-unit states.
package pipe_execute_md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/pipe_execute_md_muldiv.sv
// Iterative RV32M unit: shift-add multiply (MUL_BITS/cycle) and restoring divide (1 bit/cycle).
// Operands are captured only in IDLE; the result is held in DONE for exactly one cycle.
module pipe_execute_md_muldiv
    import pipe_execute_md_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_BITS      = 4,
    parameter int DIV_FAST_ZERO = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    md_state_e         state_q, state_d;
    logic [2*XLEN-1:0] a_q, a_d, acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, sgn_a_q, sgn_a_d;

    logic              signed_a, signed_b, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   ma, mb, fast_res;
    logic [2*XLEN-1:0] mul_sum, prod;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   rem_nx, quo_nx, quo_f, rem_f, final_res;

    // Operand classification at accept time.
    always_comb begin
        signed_a = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU)
                || (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
        signed_b = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH)
                || (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
        sa       = signed_a & a[XLEN-1];
        sb       = signed_b & b[XLEN-1];
        ma       = sa ? -a : a;
        mb       = sb ? -b : b;
        div_zero = (b == '0);
        div_ovf  = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM))
                && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        if (funct3[1])
            fast_res = div_zero ? a : '0;
        else
            fast_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration of each datapath, plus sign fix-up of the final values.
    always_comb begin
        mul_sum = acc_q;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (b_q[i])
                mul_sum = mul_sum + (a_q << i);
        end
        rem_sh = {acc_q[XLEN-1:0], b_q[XLEN-1]};
        diff   = rem_sh - {1'b0, a_q[XLEN-1:0]};
        rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_nx = {b_q[XLEN-2:0], ~diff[XLEN]};
        prod   = neg_q ? -mul_sum : mul_sum;
        quo_f  = neg_q ? -quo_nx : quo_nx;
        rem_f  = sgn_a_q ? -rem_nx : rem_nx;
        if (op_q[2])
            final_res = op_q[1] ? rem_f : quo_f;
        else
            final_res = (op_q == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        result_d = result_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_d    = funct3;
                    neg_d   = sa ^ sb;
                    sgn_a_d = sa;
                    acc_d   = '0;
                    if (funct3[2] && (DIV_FAST_ZERO != 0) && (div_zero || div_ovf)) begin
                        result_d = fast_res;
                        state_d  = MD_DONE;
                    end else if (funct3[2]) begin
                        a_d     = {{XLEN{1'b0}}, mb};
                        b_d     = ma;
                        cnt_d   = CW'(XLEN);
                        state_d = MD_BUSY;
                    end else begin
                        a_d     = {{XLEN{1'b0}}, ma};
                        b_d     = mb;
                        cnt_d   = CW'(XLEN / MUL_BITS);
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                if (op_q[2]) begin
                    acc_d = {{XLEN{1'b0}}, rem_nx};
                    b_d   = quo_nx;
                end else begin
                    acc_d = mul_sum;
                    a_d   = a_q << MUL_BITS;
                    b_d   = b_q >> MUL_BITS;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    state_d  = MD_DONE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush)
            state_d = MD_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            result_q <= result_d;
        end
    end

    assign done   = (state_q == MD_DONE);
    assign result = result_q;

endmodule

// File: rtl/pipe_execute_md.sv
// RV32IM execute stage: forwarding, ALU, branch decision/target, and a stalling M unit.
// ALU/branch paths are combinational; M ops hold StallE until their single DONE cycle.
module pipe_execute_md
    import pipe_execute_md_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_BITS      = 4,
    parameter int DIV_FAST_ZERO = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_dp_RD1E,
    input  logic [XLEN-1:0] i_dp_RD2E,
    input  logic [XLEN-1:0] i_dp_PCE,
    input  logic [XLEN-1:0] i_dp_ImmExtE,
    input  logic [XLEN-1:0] i_dp_ResultW,
    input  logic [XLEN-1:0] i_dp_ALUResultM,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic            ALUSrcE,
    input  logic [3:0]      i_dp_ALUCtrlE,
    input  logic            i_dp_JumpE,
    input  logic            i_dp_BranchE,
    input  logic            i_dp_MDE,
    input  logic [2:0]      i_dp_funct3E,
    input  logic            i_dp_FlushE,
    output logic [XLEN-1:0] o_dp_ResultE,
    output logic [XLEN-1:0] o_dp_WriteDataE,
    output logic [XLEN-1:0] o_dp_PCTargetE,
    output logic            o_dp_PCSrcE,
    output logic            o_dp_StallE
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src_a, write_data, src_b, alu_result, md_result;
    logic [SHW-1:0]  shamt;
    logic            take, md_start, md_done;

    always_comb begin
        case (ForwardAE)
            2'd1:    src_a = i_dp_ResultW;
            2'd2:    src_a = i_dp_ALUResultM;
            default: src_a = i_dp_RD1E;
        endcase
        case (ForwardBE)
            2'd1:    write_data = i_dp_ResultW;
            2'd2:    write_data = i_dp_ALUResultM;
            default: write_data = i_dp_RD2E;
        endcase
        src_b = ALUSrcE ? i_dp_ImmExtE : write_data;
        shamt = src_b[SHW-1:0];
    end

    always_comb begin
        case (i_dp_ALUCtrlE)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
            ALU_LUI:  alu_result = src_b;
            default:  alu_result = '0;
        endcase
    end

    // Branches compare against the forwarded rs2, never the immediate.
    always_comb begin
        case (i_dp_funct3E)
            FUNCT3_BRANCH_BEQ:  take = (src_a == write_data);
            FUNCT3_BRANCH_BNE:  take = (src_a != write_data);
            FUNCT3_BRANCH_BLT:  take = ($signed(src_a) < $signed(write_data));
            FUNCT3_BRANCH_BGE:  take = !($signed(src_a) < $signed(write_data));
            FUNCT3_BRANCH_BLTU: take = (src_a < write_data);
            FUNCT3_BRANCH_BGEU: take = !(src_a < write_data);
            default:            take = 1'b0;
        endcase
    end

    assign md_start = i_dp_MDE & ~i_dp_FlushE;

    pipe_execute_md_muldiv #(
        .XLEN          (XLEN),
        .MUL_BITS      (MUL_BITS),
        .DIV_FAST_ZERO (DIV_FAST_ZERO)
    ) u_muldiv (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (md_start),
        .flush  (i_dp_FlushE),
        .funct3 (i_dp_funct3E),
        .a      (src_a),
        .b      (write_data),
        .done   (md_done),
        .result (md_result)
    );

    assign o_dp_StallE     = md_start & ~md_done;
    assign o_dp_ResultE    = md_done ? md_result : alu_result;
    assign o_dp_WriteDataE = write_data;
    assign o_dp_PCTargetE  = i_dp_PCE + i_dp_ImmExtE;
    assign o_dp_PCSrcE     = ~o_dp_StallE & (i_dp_JumpE | (i_dp_BranchE & take));

endmodule

// File: doc/pipe_execute_md.md
# pipe_execute_md

Parametrised RV32IM execute stage for the five-stage pipelined core. It performs operand forwarding, ALU-source selection, ALU evaluation, branch/jump target computation and a full six-way branch decision. It adds an iterative multiply/divide unit (RV32M) whose multi-cycle operations stall the pipeline through the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- `XLEN`, default `` `XLEN`` (32): datapath width.
- `MUL_BITS`, default 4: multiplier bits retired per cycle; must divide `XLEN`.
- `DIV_FAST_ZERO`, default 1: divide-by-zero and signed overflow complete without iterating.

Ports:
- `i_clk` in 1: clock, single domain.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_dp_RD1E`, `i_dp_RD2E` in XLEN: register operands from ID/EX.
- `i_dp_PCE`, `i_dp_ImmExtE` in XLEN: PC and extended immediate.
- `i_dp_ResultW`, `i_dp_ALUResultM` in XLEN: forwarding sources from WB and MEM.
- `ForwardAE`, `ForwardBE` in 2: 0 selects register, 1 selects WB, 2 selects MEM. The value 3 is treated as 0.
- `ALUSrcE` in 1: 1 selects immediate for ALU B.
- `i_dp_ALUCtrlE` in 4: ALU operation.
- `i_dp_JumpE`, `i_dp_BranchE` in 1: jump/branch instruction in EX.
- `i_dp_MDE` in 1: M-extension instruction in EX.
- `i_dp_funct3E` in 3: branch condition or M operation.
- `i_dp_FlushE` in 1: EX flush from the hazard unit.
- `o_dp_ResultE` out XLEN: ALU result, or M result in its DONE cycle.
- `o_dp_WriteDataE` out XLEN: forwarded B operand (store data).
- `o_dp_PCTargetE` out XLEN: PC + ImmExtE.
- `o_dp_PCSrcE` out 1: redirect fetch.
- `o_dp_StallE` out 1: freeze IF/ID/EX and bubble MEM.

## Operation
- **Forwarding:**
  - SrcA = mux3(ForwardAE).
  - WriteData = mux3(ForwardBE).
  - SrcB = ALUSrcE ? Imm : WriteData.
- **Branch decision:** compare SrcA against WriteData, never the immediate.
  - BEQ tests ==; BNE tests !=.
  - BLT and BGE use signed <.
  - BLTU and BGEU use unsigned <.
  - Undefined funct3 gives no branch.
  - o_dp_PCSrcE = JumpE | (BranchE & take).
  - o_dp_PCSrcE is forced to 0 while StallE=1.
- **M unit FSM:** states IDLE, BUSY, DONE.
  - IDLE→BUSY: the operation is accepted when i_dp_MDE=1 and FlushE=0. SrcA and WriteData are latched with operand signs, and the counter is loaded.
  - IDLE→DONE instead of BUSY when `DIV_FAST_ZERO`=1 and the op is a divide-by-zero or MIN/−1 case.
  - BUSY→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on FlushE.
- **Multiply** (MUL, MULH, MULHSU, MULHU):
  - Uses 2·XLEN shift-add over magnitudes, MUL_BITS per cycle.
  - The result is negated if the operand signs differ, with signedness per op.
  - MUL returns the low half; the others return the high half.
- **Divide** (DIV, DIVU, REM, REMU):
  - Restoring shift-subtract, 1 bit per cycle.
  - Quotient sign = sign A xor sign B; remainder sign = sign A.
- **Corner cases:**
  - Divide by zero: quotient = all ones, remainder = A.
  - Signed overflow (MIN/−1): quotient = MIN, remainder = 0.
- **Stall:** o_dp_StallE = MDE & ¬FlushE & (state≠DONE).
- **Result select:** o_dp_ResultE = (state==DONE) ? md_result : alu_result.

## Timing
- Reset (async): state IDLE, counter 0, operand/result registers 0. After reset, StallE=0 until MDE rises.
- ALU, branch and target paths are combinational, with zero added latency.
- MUL latency: accept cycle, then XLEN/MUL_BITS BUSY cycles (8 at defaults), then 1 DONE cycle. StallE is high for 9 cycles; the result is valid in DONE.
- DIV latency: accept, then XLEN BUSY cycles (32), then DONE. StallE is high for 33 cycles.
- Fast path: accept, then DONE. StallE is high for 1 cycle.
- Back-to-back M ops: DONE→IDLE allows the next op to be accepted on the following cycle. There are no lost operands, because inputs are latched only in IDLE.
- Flush mid-operation: the unit returns to IDLE on the next edge, and no result is produced. FlushE in the same cycle as MDE suppresses both the stall and the accept.
- Reset mid-operation aborts immediately.

## Structure
- Add to `riscv_configs.v`: `FUNCT3_MUL`..`FUNCT3_REMU` and `FUNCT3_BRANCH_*`.
- Add to `riscv_configs.v`: FSM state encodings `MD_IDLE`, `MD_BUSY`, `MD_DONE`.
- Reuse `riscv_alu`, `riscv_mux` (N_MUX_IN 3/2) and `riscv_adder`.
- Put the FSM and the iterative datapath in one sub-module, `riscv_muldiv` (clk, rst, start, flush, funct3, a, b → busy, done, result). Place it beside the other `riscv_*` units.

## Test plan
- Forwarding: RD1=5, ResultW=7, ALUResultM=9 with ForwardAE=2, ADD with Imm=1 and ALUSrcE=1 → ResultE=10, StallE=0.
- Branches: A=0xFFFFFFFF, B=1. BLT → PCSrcE=1. BLTU → PCSrcE=0. BGEU → PCSrcE=1. PCE=0x100 with Imm=0x20 → PCTargetE=0x120.
- MULH: A=0x80000000, B=2 → StallE high for exactly 9 cycles, then ResultE=0xFFFFFFFF. MUL of the same operands → 0.
- DIV/REM: −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF after 33 stall cycles. DIVU 7/0 → 0xFFFFFFFF. REM 0x80000000/−1 → 0. Both corner cases stall for 1 cycle.
- Flush/reset: FlushE at BUSY cycle 5 of DIV → IDLE next cycle, StallE=0, no DONE result. Asserting i_rst mid-MUL → IDLE immediately; the next MUL is accepted normally.
